// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: default sizes and
// the FSM state encoding used by the top level.
package regfile_dump_reader_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int DEPTH_DEF  = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage : regfile_dump_reader_pkg

// File: rtl/regfile_dump_reader_out_reg.sv
// Enable-loaded capture register with asynchronous reset. Holds a beat field
// (word or address) stable while the downstream handshake is pending.
module dump_out_reg
  import regfile_dump_reader_pkg::*;
#(
  parameter int W = WIDTH_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wrenable,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load d when enabled; otherwise keep the captured value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= {W{1'b0}};
    end else if (wrenable) begin
      q <= d;
    end
  end

endmodule : dump_out_reg

// File: rtl/regfile_dump_reader.sv
// Read-side sequencer for the register file. A start pulse walks every
// address through the combinational read port and streams each
// (address, word) pair out on a valid/ready handshake. Never writes the file.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  output logic [WIDTH-1:0]  out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  // Last address walked; the counter stops here and never wraps.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(32'd1);

  state_t            state_r;
  state_t            state_s;
  logic [ADDR_W-1:0] rd_addr_r;
  logic [ADDR_W-1:0] rd_addr_s;
  logic              out_valid_r;
  logic              out_valid_s;
  logic              busy_r;
  logic              busy_s;
  logic              done_r;
  logic              done_s;
  logic              load_s;

  // Next-state and next-output decode; all outputs are registered so every
  // flag below is the value for the following cycle.
  always_comb begin
    state_s     = state_r;
    rd_addr_s   = rd_addr_r;
    out_valid_s = out_valid_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s   = ST_READ;
          rd_addr_s = {ADDR_W{1'b0}};
          busy_s    = 1'b1;
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_READ: begin
        state_s     = ST_HOLD;
        out_valid_s = 1'b1;
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_s = 1'b0;
          if (rd_addr_r == LAST_ADDR) begin
            state_s = ST_DONE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end else begin
            state_s   = ST_READ;
            rd_addr_s = rd_addr_r + ADDR_ONE;
          end
        end else begin
          state_s = ST_HOLD;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s     = ST_IDLE;
        rd_addr_s   = {ADDR_W{1'b0}};
        out_valid_s = 1'b0;
        busy_s      = 1'b0;
      end
    endcase
  end

  // State, address counter and handshake/status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      rd_addr_r   <= {ADDR_W{1'b0}};
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      rd_addr_r   <= rd_addr_s;
      out_valid_r <= out_valid_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

  // Capture the word exactly once per beat, in the READ cycle; a write landing
  // on the same edge is therefore not seen.
  assign load_s = (state_r == ST_READ);

  dump_out_reg #(.W(WIDTH)) u_data_reg (
    .clk      (clk),
    .reset    (reset),
    .wrenable (load_s),
    .d        (rd_data),
    .q        (out_data)
  );

  dump_out_reg #(.W(ADDR_W)) u_addr_reg (
    .clk      (clk),
    .reset    (reset),
    .wrenable (load_s),
    .d        (rd_addr_r),
    .q        (out_addr)
  );

  assign rd_addr   = rd_addr_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule : regfile_dump_reader

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: a 32-word regfile model feeds a DEPTH=32
// instance and a DEPTH=4 instance; a per-dump timeline model derived from
// the handshake rules predicts every cycle's outputs.
module tb_regfile_dump_reader;

  localparam int MAXC = 512;

  logic        clk = 1'b0;
  logic        reset;

  logic        start_a, out_ready_a, out_valid_a, busy_a, done_a;
  logic [4:0]  rd_addr_a, out_addr_a;
  logic [31:0] rd_data_a, out_data_a;

  logic        start_b, out_ready_b, out_valid_b, busy_b, done_b;
  logic [1:0]  rd_addr_b, out_addr_b;
  logic [31:0] rd_data_b, out_data_b;

  logic [31:0] regs     [32];
  logic [31:0] init_val [32];
  logic        init_req, wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  int n_checks = 0;
  int n_err    = 0;

  bit          rdy  [MAXC];
  bit          ev   [MAXC];
  int          ek   [MAXC];
  bit          eb   [MAXC];
  bit          ed   [MAXC];
  logic [31:0] emem [32];

  always #5 clk = ~clk;

  // Register file model: bulk load or a single write port.
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 32; i++) regs[i] <= init_val[i];
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[{3'b000, rd_addr_b}];

  regfile_dump_reader #(.WIDTH(32), .DEPTH(32), .ADDR_W(5)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .rd_addr(rd_addr_a),
    .rd_data(rd_data_a), .out_data(out_data_a), .out_addr(out_addr_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .busy(busy_a), .done(done_a)
  );

  regfile_dump_reader #(.WIDTH(32), .DEPTH(4), .ADDR_W(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .rd_addr(rd_addr_b),
    .rd_data(rd_data_b), .out_data(out_data_b), .out_addr(out_addr_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .busy(busy_b), .done(done_b)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_regs(input bit rnd);
    for (int i = 0; i < 32; i++) init_val[i] = rnd ? $urandom : (32'hA500_0000 + 32'(i));
    init_req = 1'b1;
    @(posedge clk); #1;
    init_req = 1'b0;
  endtask

  // One full dump. Called #1 after a posedge with the DUT idle; cycle 0 is
  // the cycle in which start is held high. rmode: 0 ready=1, 1 ready low for
  // cycles 8..12, 2 random ready, 3 ready on odd cycles.
  task automatic run_dump(input int sel, input int rmode, input int wr_cyc,
                          input int xs1, input int xs2,
                          output int beats, output int done_at, output logic [31:0] beat7);
    int depth, t, offer, last, done_c, ncyc;
    logic ov, ob, od;
    logic [4:0] oa, ra;
    logic [31:0] odat;
    depth = (sel == 1) ? 4 : 32;
    for (int c = 0; c < MAXC; c++) begin
      case (rmode)
        0:       rdy[c] = 1'b1;
        1:       rdy[c] = !(c >= 8 && c <= 12);
        2:       rdy[c] = ($urandom_range(0, 3) != 0);
        default: rdy[c] = (c % 2 == 1);
      endcase
      ev[c] = 1'b0; ek[c] = 0; eb[c] = 1'b0; ed[c] = 1'b0;
    end
    for (int k = 0; k < 32; k++) emem[k] = regs[k];
    // Timeline: beat k is offered, held until the first ready cycle, and the
    // next beat is offered two cycles after that acceptance.
    t = 2; last = 2;
    for (int k = 0; k < depth; k++) begin
      offer = t;
      while (!rdy[t] && t < MAXC - 8) t++;
      for (int c = offer; c <= t; c++) begin ev[c] = 1'b1; ek[c] = k; end
      last = t;
      t = t + 2;
    end
    done_c = last + 1;
    for (int c = 1; c < done_c; c++) eb[c] = 1'b1;
    ed[done_c] = 1'b1;
    ncyc = done_c + 3;
    beats = 0; done_at = -1; beat7 = 32'h0;
    for (int c = 0; c <= ncyc; c++) begin
      start_a     = (sel == 0) && (c == 0 || c == xs1 || c == xs2);
      start_b     = (sel == 1) && (c == 0 || c == xs1 || c == xs2);
      out_ready_a = (sel == 0) ? rdy[c] : 1'b0;
      out_ready_b = (sel == 1) ? rdy[c] : 1'b0;
      wr_en       = (c == wr_cyc);
      ov   = (sel == 1) ? out_valid_b : out_valid_a;
      ob   = (sel == 1) ? busy_b : busy_a;
      od   = (sel == 1) ? done_b : done_a;
      oa   = (sel == 1) ? {3'b000, out_addr_b} : out_addr_a;
      ra   = (sel == 1) ? {3'b000, rd_addr_b} : rd_addr_a;
      odat = (sel == 1) ? out_data_b : out_data_a;
      check_val($sformatf("valid_s%0d_c%0d", sel, c), {63'd0, ov}, {63'd0, ev[c]});
      check_val($sformatf("busy_s%0d_c%0d", sel, c), {63'd0, ob}, {63'd0, eb[c]});
      check_val($sformatf("done_s%0d_c%0d", sel, c), {63'd0, od}, {63'd0, ed[c]});
      if (ev[c]) begin
        check_val($sformatf("addr_s%0d_c%0d", sel, c), {59'd0, oa}, 64'(ek[c]));
        check_val($sformatf("rdaddr_s%0d_c%0d", sel, c), {59'd0, ra}, 64'(ek[c]));
        check_val($sformatf("data_s%0d_c%0d", sel, c), {32'd0, odat}, {32'd0, emem[ek[c]]});
      end
      if (c >= done_c) begin
        check_val($sformatf("nowrap_s%0d_c%0d", sel, c), {59'd0, ra}, 64'(depth - 1));
      end
      if (ov && rdy[c]) beats++;
      if (ov && oa == 5'd7) beat7 = odat;
      if (od && done_at < 0) done_at = c;
      @(posedge clk); #1;
    end
    start_a = 1'b0; start_b = 1'b0; out_ready_a = 1'b0; out_ready_b = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    int beats, done_at;
    logic [31:0] b7;
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; out_ready_a = 1'b0; out_ready_b = 1'b0;
    init_req = 1'b0; wr_en = 1'b0; wr_addr = 5'd7; wr_data = 32'hDEAD_BEEF;
    #2;
    check_val("rst_valid_a", {63'd0, out_valid_a}, 64'd0);
    check_val("rst_busy_a",  {63'd0, busy_a}, 64'd0);
    check_val("rst_done_a",  {63'd0, done_a}, 64'd0);
    check_val("rst_rdaddr_a", {59'd0, rd_addr_a}, 64'd0);
    check_val("rst_oaddr_a", {59'd0, out_addr_a}, 64'd0);
    check_val("rst_odata_a", {32'd0, out_data_a}, 64'd0);
    check_val("rst_valid_b", {63'd0, out_valid_b}, 64'd0);
    load_regs(1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: plain dump, ready tied high
    run_dump(0, 0, -1, -1, -1, beats, done_at, b7);
    check_val("t1_beats", 64'(beats), 64'd32);
    check_val("t1_done_cycle", 64'(done_at), 64'd65);

    // 2: ready low for 5 cycles while beat 3 is held
    run_dump(0, 1, -1, -1, -1, beats, done_at, b7);
    check_val("t2_beats", 64'(beats), 64'd32);
    check_val("t2_done_cycle", 64'(done_at), 64'd70);

    // 3: write reg 7 on the edge that captures beat 7, then dump again
    wr_addr = 5'd7; wr_data = 32'hDEAD_BEEF;
    run_dump(0, 0, 15, -1, -1, beats, done_at, b7);
    check_val("t3_beat7_old", {32'd0, b7}, 64'h0000_0000_A500_0007);
    run_dump(0, 0, -1, -1, -1, beats, done_at, b7);
    check_val("t3_beat7_new", {32'd0, b7}, 64'h0000_0000_DEAD_BEEF);

    // 4: stray start pulses during an active dump
    run_dump(0, 0, -1, 3, 10, beats, done_at, b7);
    check_val("t4_beats", 64'(beats), 64'd32);
    check_val("t4_done_cycle", 64'(done_at), 64'd65);

    // 5: asynchronous reset while beat 12 is held
    load_regs(1'b0);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; out_ready_a = 1'b1;
    for (int c = 1; c < 26; c++) begin @(posedge clk); #1; end
    check_val("t5_hold_valid", {63'd0, out_valid_a}, 64'd1);
    check_val("t5_hold_addr", {59'd0, out_addr_a}, 64'd12);
    #2 reset = 1'b1;
    #1;
    check_val("t5_rst_valid", {63'd0, out_valid_a}, 64'd0);
    check_val("t5_rst_busy", {63'd0, busy_a}, 64'd0);
    check_val("t5_rst_done", {63'd0, done_a}, 64'd0);
    check_val("t5_rst_rdaddr", {59'd0, rd_addr_a}, 64'd0);
    check_val("t5_rst_odata", {32'd0, out_data_a}, 64'd0);
    out_ready_a = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    run_dump(0, 0, -1, -1, -1, beats, done_at, b7);
    check_val("t5_redump_beats", 64'(beats), 64'd32);

    // 6: four-deep instance with ready toggling every cycle
    run_dump(1, 3, -1, -1, -1, beats, done_at, b7);
    check_val("t6_beats", 64'(beats), 64'd4);

    // 7: random contents and random back-pressure
    for (int r = 0; r < 3; r++) begin
      load_regs(1'b1);
      run_dump(0, 2, -1, $urandom_range(1, 40), -1, beats, done_at, b7);
      check_val($sformatf("t7_beats_r%0d", r), 64'(beats), 64'd32);
      run_dump(1, 2, -1, -1, -1, beats, done_at, b7);
      check_val($sformatf("t7b_beats_r%0d", r), 64'(beats), 64'd4);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_regfile_dump_reader
